lcd_arbiter: RTL
================

LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 16, giving the maximum cycles to wait for lcd_busy to rise after issue.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req  input  NREQ  per-requester command request, held until ack or err for that requester.
REQ-006 req_lock  input  NREQ  per-requester lock: keep the grant across consecutive commands.
REQ-007 req_bus  input  NREQ*10  per-requester command {rs, rw, data[7:0]}; slice i is bits [10*i+9:10*i].
REQ-008 ack  output  NREQ  one-cycle pulse: granted command completed.
REQ-009 err  output  1  one-cycle pulse: issued command timed out.
REQ-010 grant_id  output  clog2(NREQ)  index of the currently or last granted requester.
REQ-011 lcd_busy  input  1  busy flag from the LCD driver.
REQ-012 lcd_enable  output  1  command strobe to the LCD driver.
REQ-013 lcd_bus  output  10  command to the LCD driver {rs, rw, data}.
REQ-014 idle  output  1  high when the FSM is in IDLE.

Function
REQ-015 SHALL implement a registered FSM with states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-016 IDLE -> ISSUE SHALL occur when any req bit is high and lcd_busy is 0.
- The winner is chosen round-robin, starting at the index after the last granted one.
- The winner's req_bus slice is latched into lcd_bus, and grant_id is updated on the same edge.
REQ-017 ISSUE SHALL drive lcd_enable=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-018 lcd_enable SHALL be 0 in every state other than ISSUE.
REQ-019 WAIT_BUSY SHALL go to WAIT_DONE on the first cycle lcd_busy=1.
- A counter cleared on entry counts cycles in WAIT_BUSY.
- When the counter reaches BUSY_TIMEOUT with lcd_busy still 0: pulse err for one cycle, go to IDLE, no ack.
REQ-020 WAIT_DONE SHALL, on the first cycle lcd_busy=0, pulse ack[grant_id] for one cycle and go to IDLE.
REQ-021 Lock: if req_lock[grant_id] and req[grant_id] are both high in the ack cycle, the next IDLE->ISSUE SHALL re-grant the same requester regardless of the other requests.
REQ-022 Lock SHALL be ignored after an err; the round-robin pointer then advances normally.
REQ-023 lcd_bus SHALL stay stable from the issue edge until the next grant, even if req drops mid-transaction.
REQ-024 A dropped req SHALL not abort the transaction; its ack still pulses.
REQ-025 A request whose req falls before it is granted SHALL be dropped silently.
REQ-026 Minimum turnaround SHALL be as follows.
- ack in cycle N, IDLE in cycle N+1, next lcd_enable no earlier than cycle N+2.
- At most one ack or err pulse per transaction.
REQ-027 The round-robin pointer SHALL wrap from NREQ-1 to 0.
- Only requesters with req high are considered.
- A single requester is re-granted back-to-back.
REQ-028 No more than one bit of ack SHALL be high in any cycle, and ack and err SHALL never be high together.

Reset
REQ-029 While rst_n=0 the block SHALL hold:
- state IDLE;
- lcd_enable=0, lcd_bus=0, ack=0, err=0;
- grant_id=NREQ-1, so requester 0 has first priority;
- lock cleared, timeout counter 0, idle=1.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction with no ack or err.
- Operation resumes from IDLE on the first rising edge after rst_n deasserts.

Structure
REQ-031 A shared package lcd_pkg SHALL hold:
- the FSM state enum;
- the 10-bit lcd command struct {rs, rw, data};
- the default BUSY_TIMEOUT;
- the standard LCD command constants (clear 8'h01, entry mode 8'h06, display on 8'h0C).
REQ-032 The round-robin selection SHALL be a combinational sub-module rr_picker: inputs req and the last-grant pointer; outputs a valid flag and the winner index.

Verification
REQ-033 Four requesters, reqs 0 and 2 high, lcd model busy for 5 cycles after each strobe -> grants 0, 2, 0, 2 in order, one ack per command, lcd_bus equals the corresponding req_bus slice.
REQ-034 Requester 1 locked, 3 commands; requester 3 requesting throughout -> requester 1 gets 3 consecutive acks, then requester 3 is granted.
REQ-035 lcd_busy tied 0 after a strobe, BUSY_TIMEOUT=16 -> err pulses exactly 16 cycles after leaving ISSUE, no ack, FSM idle the next cycle.
REQ-036 lcd_busy=1 when a req arrives -> no lcd_enable until lcd_busy falls; then one strobe exactly 2 cycles later.
REQ-037 rst_n pulsed low during WAIT_DONE -> outputs reach reset values immediately (asynchronous), no ack; after release, a pending req 3 is reissued with grant_id=3.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command arbiter.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } lcd_cmd_t;

    localparam int LCD_BUSY_TIMEOUT_DEFAULT = 16;

    localparam logic [7:0] LCD_CMD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] LCD_CMD_DISPLAY_ON = 8'h0C;

endpackage

// File: rtl/lcd_arbiter_rr_picker.sv
// Combinational round-robin picker: the first active request strictly after
// the last-granted index wins, wrapping from NREQ-1 back to 0.
module rr_picker #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic            valid_o,
    output logic [IDW-1:0]  winner_o
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW:0]      start;
    logic [IDW:0]      off;
    logic [IDW:0]      pos;

    assign start = (last_i == IDW'(NREQ - 1)) ? '0 : ({1'b0, last_i} + 1'b1);
    assign dbl   = {req_i, req_i};
    // rot[m] is the request sitting m places after the start position.
    assign rot   = NREQ'(dbl >> start);

    always_comb begin
        valid_o = |req_i;
        off     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = (IDW+1)'(k);
            end
        end
        pos = start + off;
        if (pos >= (IDW+1)'(NREQ)) begin
            pos = pos - (IDW+1)'(NREQ);
        end
        winner_o = pos[IDW-1:0];
    end

endmodule

// File: rtl/lcd_arbiter.sv
// Arbitrates NREQ command requesters onto a single LCD driver port with
// round-robin fairness, optional grant locking and a busy-rise timeout.
module lcd_arbiter
    import lcd_pkg::*;
#(
    parameter  int NREQ         = 4,
    parameter  int BUSY_TIMEOUT = LCD_BUSY_TIMEOUT_DEFAULT,
    localparam int IDW          = $clog2(NREQ),
    localparam int CNTW         = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_lock,
    input  logic [NREQ*10-1:0] req_bus,
    output logic [NREQ-1:0]    ack,
    output logic               err,
    output logic [IDW-1:0]     grant_id,
    input  logic               lcd_busy,
    output logic               lcd_enable,
    output logic [9:0]         lcd_bus,
    output logic               idle
);

    lcd_state_e      state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    lcd_cmd_t        bus_q, bus_d;
    logic            lock_q, lock_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            busy_q;

    lcd_cmd_t        req_cmd [NREQ];
    logic            pick_valid;
    logic [IDW-1:0]  pick_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign req_cmd[gi] = req_bus[10*gi +: 10];
        end
    endgenerate

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req_i    (req),
        .last_i   (grant_q),
        .valid_o  (pick_valid),
        .winner_o (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= IDW'(NREQ - 1);
            bus_q   <= '0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            bus_q   <= bus_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            busy_q  <= lcd_busy;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        bus_d   = bus_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        ack     = '0;
        err     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Busy must read low on two consecutive samples before a new issue.
                if (pick_valid && !lcd_busy && !busy_q) begin
                    state_d = ST_ISSUE;
                    lock_d  = 1'b0;
                    if (lock_q && req[grant_q]) begin
                        grant_d = grant_q;
                    end else begin
                        grant_d = pick_idx;
                    end
                    bus_d = req_cmd[grant_d];
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
                cnt_d   = '0;
            end
            ST_WAIT_BUSY: begin
                if (lcd_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNTW'(BUSY_TIMEOUT)) begin
                    err     = 1'b1;
                    lock_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!lcd_busy) begin
                    ack     = NREQ'(1) << grant_q;
                    lock_d  = req_lock[grant_q] & req[grant_q];
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign lcd_enable = (state_q == ST_ISSUE);
    assign idle       = (state_q == ST_IDLE);
    assign grant_id   = grant_q;
    assign lcd_bus    = bus_q;

endmodule
